// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice allocator.
//   alloc_state_t : allocator FSM state (IDLE accepts events, RETRIG holds a
//                   reused voice's gate low before re-raising it).
//   voice_class_t : per-voice classification used by the target picker.
//   rank_w()      : width of a voice rank / voice index for a given voice count.
package synth_pkg;

    typedef enum logic {
        IDLE,
        RETRIG
    } alloc_state_t;

    typedef enum logic [1:0] {
        IDLE_V,
        RELEASING_V,
        GATED_V
    } voice_class_t;

    // Ranks are 0..VOICES-1, so the same width also indexes a voice.
    function automatic int rank_w(input int voices);
        return (voices > 1) ? $clog2(voices) : 1;
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational note-on target picker.
// Ports:
//   gate_i, running_i : per-voice Gate / Running, used to classify voices
//   vnote_i           : note held by each voice
//   rank_i            : per-voice age rank (0 = newest)
//   note_i            : note number of the incoming note-on
//   target_o          : chosen voice index
//   retrig_o          : target already holds this note (same-note reuse)
//   steal_o           : target is a non-idle voice holding a different note
module voice_select
    import synth_pkg::*;
#(
    parameter int VOICES     = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int RW         = 2
) (
    input  logic [VOICES-1:0]                 gate_i,
    input  logic [VOICES-1:0]                 running_i,
    input  logic [VOICES-1:0][NOTE_WIDTH-1:0] vnote_i,
    input  logic [VOICES-1:0][RW-1:0]         rank_i,
    input  logic [NOTE_WIDTH-1:0]             note_i,
    output logic [RW-1:0]                     target_o,
    output logic                              retrig_o,
    output logic                              steal_o
);

    voice_class_t cls [VOICES];

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            if (gate_i[v])         cls[v] = GATED_V;
            else if (running_i[v]) cls[v] = RELEASING_V;
            else                   cls[v] = IDLE_V;
        end
    end

    logic          found_m, found_i, found_r, found_g;
    logic [RW-1:0] idx_m, idx_i, idx_r, idx_g;
    logic [RW-1:0] rank_r, rank_g;

    // One pass finds all four candidates; ascending scan with "first found"
    // guards gives lowest index, rank compare gives the oldest.
    always_comb begin
        found_m = 1'b0; found_i = 1'b0; found_r = 1'b0; found_g = 1'b0;
        idx_m   = '0;   idx_i   = '0;   idx_r   = '0;   idx_g   = '0;
        rank_r  = '0;   rank_g  = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (!found_m && cls[v] != IDLE_V && vnote_i[v] == note_i) begin
                found_m = 1'b1;
                idx_m   = RW'(v);
            end
            if (!found_i && cls[v] == IDLE_V) begin
                found_i = 1'b1;
                idx_i   = RW'(v);
            end
            if (cls[v] == RELEASING_V && (!found_r || rank_i[v] > rank_r)) begin
                found_r = 1'b1;
                idx_r   = RW'(v);
                rank_r  = rank_i[v];
            end
            if (cls[v] == GATED_V && (!found_g || rank_i[v] > rank_g)) begin
                found_g = 1'b1;
                idx_g   = RW'(v);
                rank_g  = rank_i[v];
            end
        end
    end

    // With no idle or releasing voice every voice is gated, so the last
    // branch always has a valid candidate.
    always_comb begin
        retrig_o = 1'b0;
        steal_o  = 1'b0;
        if (found_m) begin
            target_o = idx_m;
            retrig_o = 1'b1;
        end else if (found_i) begin
            target_o = idx_i;
        end else if (found_r) begin
            target_o = idx_r;
            steal_o  = 1'b1;
        end else begin
            target_o = idx_g;
            steal_o  = 1'b1;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-event front end for a bank of envelope generators.
// Ports:
//   Clock, Reset        : rising-edge clock, async active-low reset
//   NoteValid/NoteOn/Note : note event in, accepted when NoteValid && NoteReady
//   NoteReady           : low while a reused gated voice is held low
//   Running             : per-voice Running from the envelope generators
//   Gate                : per-voice gate to the envelope generators
//   VoiceNote           : note held by voice v at [v*NOTE_WIDTH +: NOTE_WIDTH]
//   Stolen              : one-cycle pulse when a note-on takes a busy voice
module voice_allocator
    import synth_pkg::*;
#(
    parameter int VOICES        = 4,
    parameter int NOTE_WIDTH    = 7,
    parameter int RETRIG_CYCLES = 1
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         NoteValid,
    input  logic                         NoteOn,
    input  logic [NOTE_WIDTH-1:0]        Note,
    output logic                         NoteReady,
    input  logic [VOICES-1:0]            Running,
    output logic [VOICES-1:0]            Gate,
    output logic [VOICES*NOTE_WIDTH-1:0] VoiceNote,
    output logic                         Stolen
);

    localparam int RW = rank_w(VOICES);
    localparam int CW = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;

    alloc_state_t                     state_q;
    logic [VOICES-1:0]                gate_q;
    logic [VOICES-1:0][NOTE_WIDTH-1:0] vnote_q;
    logic [VOICES-1:0][RW-1:0]        rank_q;
    logic                             stolen_q;
    logic                             ready_q;
    logic [CW-1:0]                    cnt_q;
    logic [RW-1:0]                    held_q;

    logic [RW-1:0] tgt;
    logic          tgt_retrig;
    logic          tgt_steal;

    voice_select #(
        .VOICES     (VOICES),
        .NOTE_WIDTH (NOTE_WIDTH),
        .RW         (RW)
    ) u_sel (
        .gate_i    (gate_q),
        .running_i (Running),
        .vnote_i   (vnote_q),
        .rank_i    (rank_q),
        .note_i    (Note),
        .target_o  (tgt),
        .retrig_o  (tgt_retrig),
        .steal_o   (tgt_steal)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            gate_q   <= '0;
            vnote_q  <= '0;
            stolen_q <= 1'b0;
            ready_q  <= 1'b1;
            cnt_q    <= '0;
            held_q   <= '0;
            for (int v = 0; v < VOICES; v++) rank_q[v] <= RW'(v);
        end else begin
            stolen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (NoteValid && NoteOn) begin
                        vnote_q[tgt] <= Note;
                        stolen_q     <= tgt_steal;
                        // Move target to newest; everyone younger ages by one.
                        for (int v = 0; v < VOICES; v++)
                            if (rank_q[v] < rank_q[tgt]) rank_q[v] <= rank_q[v] + 1'b1;
                        rank_q[tgt] <= '0;
                        if (gate_q[tgt]) begin
                            // Reusing a gated voice: drop gate so the envelope
                            // sees a fresh rising edge after the hold.
                            gate_q[tgt] <= 1'b0;
                            state_q     <= RETRIG;
                            ready_q     <= 1'b0;
                            cnt_q       <= CW'(RETRIG_CYCLES - 1);
                            held_q      <= tgt;
                        end else begin
                            gate_q[tgt] <= 1'b1;
                        end
                    end else if (NoteValid) begin
                        for (int v = 0; v < VOICES; v++)
                            if (gate_q[v] && vnote_q[v] == Note) gate_q[v] <= 1'b0;
                    end
                end
                RETRIG: begin
                    if (cnt_q == '0) begin
                        gate_q[held_q] <= 1'b1;
                        state_q        <= IDLE;
                        ready_q        <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign NoteReady = ready_q;
    assign Gate      = gate_q;
    assign VoiceNote = vnote_q;
    assign Stolen    = stolen_q;

    // Same-note reuse is a plain retrigger; the flag is informational only.
    logic unused_retrig;
    assign unused_retrig = tgt_retrig;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against an age-queue reference model.
module tb_voice_allocator;

    localparam int V  = 4;
    localparam int NW = 7;
    localparam int RC = 1;

    logic            Clock = 1'b0;
    logic            Reset;
    logic            NoteValid;
    logic            NoteOn;
    logic [NW-1:0]   Note;
    logic            NoteReady;
    logic [V-1:0]    Running;
    logic [V-1:0]    Gate;
    logic [V*NW-1:0] VoiceNote;
    logic            Stolen;

    voice_allocator #(.VOICES(V), .NOTE_WIDTH(NW), .RETRIG_CYCLES(RC)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .NoteValid (NoteValid),
        .NoteOn    (NoteOn),
        .Note      (Note),
        .NoteReady (NoteReady),
        .Running   (Running),
        .Gate      (Gate),
        .VoiceNote (VoiceNote),
        .Stolen    (Stolen)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: age kept as a queue, newest voice at the front.
    bit          m_gate [V];
    logic [NW-1:0] m_note [V];
    int          order[$];
    int          m_pend;
    int          m_held;
    bit          m_ready;
    bit          m_stolen;

    task automatic model_reset();
        order.delete();
        for (int v = 0; v < V; v++) begin
            m_gate[v] = 0;
            m_note[v] = '0;
            order.push_back(v);
        end
        m_pend = 0; m_held = 0; m_ready = 1; m_stolen = 0;
    endtask

    function automatic bit is_idle(input int v);
        return !m_gate[v] && !Running[v];
    endfunction

    task automatic pick(output int t, output bit st);
        for (int v = 0; v < V; v++)
            if (!is_idle(v) && m_note[v] == Note) begin t = v; st = 0; return; end
        for (int v = 0; v < V; v++)
            if (is_idle(v)) begin t = v; st = 0; return; end
        for (int i = order.size() - 1; i >= 0; i--)
            if (!m_gate[order[i]] && Running[order[i]]) begin t = order[i]; st = 1; return; end
        t = order[order.size() - 1];
        st = 1;
    endtask

    task automatic model_step();
        int t;
        bit st;
        m_stolen = 0;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin m_gate[m_held] = 1; m_ready = 1; end
        end else if (NoteValid && m_ready && NoteOn) begin
            pick(t, st);
            for (int i = 0; i < order.size(); i++)
                if (order[i] == t) begin order.delete(i); break; end
            order.push_front(t);
            m_stolen  = st;
            m_note[t] = Note;
            if (m_gate[t]) begin
                m_gate[t] = 0; m_pend = RC; m_held = t; m_ready = 0;
            end else begin
                m_gate[t] = 1;
            end
        end else if (NoteValid && m_ready) begin
            for (int v = 0; v < V; v++)
                if (m_gate[v] && m_note[v] == Note) m_gate[v] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [V-1:0]    g;
        logic [V*NW-1:0] vn;
        for (int v = 0; v < V; v++) begin
            g[v] = m_gate[v];
            vn[v*NW +: NW] = m_note[v];
        end
        chk({tag, ".gate"},  Gate,      g);
        chk({tag, ".note"},  VoiceNote, vn);
        chk({tag, ".stol"},  Stolen,    m_stolen);
        chk({tag, ".ready"}, NoteReady, m_ready);
    endtask

    // Inputs are stable here; advance model and DUT one edge, then compare.
    task automatic cycle(input string tag);
        model_step();
        @(posedge Clock); #1;
        check_all(tag);
    endtask

    task automatic ev(input bit vld, input bit on, input int n);
        NoteValid = vld; NoteOn = on; Note = NW'(n);
    endtask

    initial begin
        Reset = 1'b0; NoteValid = 0; NoteOn = 0; Note = '0; Running = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all("reset");
        Reset = 1'b1;

        // 1: first note lands on voice 0
        ev(1, 1, 60); cycle("t1");
        chk("t1.gate0", Gate, 4'b0001);
        chk("t1.vn0", VoiceNote[NW-1:0], 60);

        // 2: fill all voices, then steal the oldest (voice 0)
        ev(1, 1, 62); cycle("t2a");
        ev(1, 1, 64); cycle("t2b");
        ev(1, 1, 65); cycle("t2c");
        chk("t2.full", Gate, 4'b1111);
        ev(1, 1, 67); cycle("t2d");
        chk("t2.low",  Gate, 4'b1110);
        chk("t2.rdy0", NoteReady, 0);
        chk("t2.stol", Stolen, 1);
        ev(0, 0, 0); cycle("t2e");
        chk("t2.high", Gate, 4'b1111);
        chk("t2.vn0",  VoiceNote[NW-1:0], 67);
        chk("t2.stol1", Stolen, 0);

        // 3: release voice 1, then steal it while releasing
        Running = 4'hF;
        ev(1, 0, 62); cycle("t3a");
        chk("t3.off", Gate, 4'b1101);
        ev(1, 1, 69); cycle("t3b");
        chk("t3.on",   Gate, 4'b1111);
        chk("t3.stol", Stolen, 1);
        chk("t3.vn1",  VoiceNote[NW +: NW], 69);

        // 4: note-off with no holder
        ev(1, 0, 50); cycle("t4");
        chk("t4.gate", Gate, 4'b1111);

        // 5/6: same-note retrigger of voice 2, with next event held pending
        ev(1, 1, 64); cycle("t5a");
        chk("t5.low",  Gate, 4'b1011);
        chk("t5.stol", Stolen, 0);
        ev(1, 1, 70); cycle("t6a");
        chk("t6.high", Gate, 4'b1111);
        chk("t6.vn2",  VoiceNote[2*NW +: NW], 64);
        cycle("t6b");
        chk("t6.steal", Stolen, 1);
        chk("t6.rdy0",  NoteReady, 0);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        chk("t6.rgate", Gate, 0);
        chk("t6.rrdy",  NoteReady, 1);
        ev(0, 0, 0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        Running = '0;
        cycle("t6c");
        cycle("t6d");
        chk("t6.norise", Gate, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (m_ready)
                ev($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 60 + $urandom_range(0, 7));
            for (int v = 0; v < V; v++)
                Running[v] = m_gate[v] | ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
